// File: rtl/jtag_master_shifter.sv
// jtag_master_shifter: JTAG initiator that runs one IR scan, DR scan or TAP reset per command
// from Run_Test_Idle back to Run_Test_Idle, with TCK divided down from the system clock.
module jtag_master_shifter #(
  parameter int MAX_LEN = 32,
  parameter int DIV = 4,
  localparam int LW = $clog2(MAX_LEN) + 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [1:0]         cmd_i,
  input  logic [LW-1:0]      len_i,
  input  logic [MAX_LEN-1:0] din_i,
  output logic [MAX_LEN-1:0] dout_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i
);
  localparam int CW = LW + 2;
  localparam int PW = $clog2(2 * DIV);
  typedef enum logic [2:0] {IDLE, SYNC, PRE, SHIFT, POST, FIN} state_t;
  state_t state_q, state_d, nst;
  logic sync_q, sync_d, err_q, err_d, tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d, last, bad;
  logic [1:0] cmd_q, cmd_d;
  logic [LW-1:0] len_q, len_d;
  logic [MAX_LEN-1:0] din_q, din_d, cap_q, cap_d, dout_q, dout_d, dsh;
  logic [CW-1:0] cnt_q, cnt_d, ncnt, lenm1;
  logic [PW-1:0] ph_q, ph_d;
  assign lenm1 = CW'(len_q) - CW'(1);
  assign bad = cmd_i == 2'b11 || (cmd_i != 2'b10 && (len_i == '0 || len_i > LW'(MAX_LEN)));
  assign dsh = din_q >> ncnt;
  // Where the edge sequencer goes once the current TCK period ends.
  always_comb begin
    last = state_q == SYNC ? cnt_q == CW'(5) :
           state_q == PRE ? cnt_q == (cmd_q == 2'b00 ? CW'(3) : CW'(2)) :
           state_q == SHIFT ? cnt_q == lenm1 : cnt_q == CW'(1);
    nst = !last ? state_q : state_q == SYNC ? (cmd_q == 2'b10 ? FIN : PRE) :
          state_q == PRE ? SHIFT : state_q == SHIFT ? POST : FIN;
    ncnt = last ? '0 : cnt_q + CW'(1);
  end
  always_comb begin
    state_d = state_q;
    sync_d = sync_q;
    err_d = err_q;
    tck_d = tck_q;
    tms_d = tms_q;
    tdi_d = tdi_q;
    cmd_d = cmd_q;
    len_d = len_q;
    din_d = din_q;
    cap_d = cap_q;
    dout_d = dout_q;
    cnt_d = cnt_q;
    ph_d = ph_q;
    if (state_q == IDLE || state_q == FIN) begin
      state_d = IDLE;
      err_d = 1'b0;
      if (start_i) begin
        cmd_d = cmd_i;
        len_d = len_i;
        din_d = din_i;
        if (bad) begin
          state_d = FIN;
          err_d = 1'b1;
        end else begin
          // Both SYNC and PRE open with a TMS=1, TDI=0 edge.
          state_d = (cmd_i == 2'b10 || !sync_q) ? SYNC : PRE;
          cnt_d = '0;
          ph_d = '0;
          cap_d = '0;
          tms_d = 1'b1;
          tdi_d = 1'b0;
        end
      end
    end else begin
      ph_d = ph_q + PW'(1);
      if (ph_q == PW'(DIV - 1)) tck_d = 1'b1;
      if (ph_q == PW'(2 * DIV - 1)) begin
        ph_d = '0;
        tck_d = 1'b0;
        if (state_q == SHIFT) cap_d = cap_q | (MAX_LEN'(tdo_i) << cnt_q);
        if (state_q == SYNC && last) sync_d = 1'b1;
        state_d = nst;
        cnt_d = ncnt;
        tms_d = nst == SYNC ? ncnt < CW'(5) :
                nst == PRE ? (cmd_q == 2'b00 ? ncnt < CW'(2) : ncnt == '0) :
                nst == SHIFT ? ncnt == lenm1 : nst == POST && ncnt == '0;
        tdi_d = nst == SHIFT && dsh[0];
        if (state_q == POST && nst == FIN) dout_d = cap_d;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      sync_q <= 1'b0;
      err_q <= 1'b0;
      tck_q <= 1'b0;
      tms_q <= 1'b0;
      tdi_q <= 1'b0;
      cmd_q <= '0;
      len_q <= '0;
      din_q <= '0;
      cap_q <= '0;
      dout_q <= '0;
      cnt_q <= '0;
      ph_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      err_q <= err_d;
      tck_q <= tck_d;
      tms_q <= tms_d;
      tdi_q <= tdi_d;
      cmd_q <= cmd_d;
      len_q <= len_d;
      din_q <= din_d;
      cap_q <= cap_d;
      dout_q <= dout_d;
      cnt_q <= cnt_d;
      ph_q <= ph_d;
    end
  end
  assign busy_o = !(state_q == IDLE || state_q == FIN);
  assign done_o = state_q == FIN;
  assign err_o = err_q;
  assign dout_o = dout_q;
  assign tck_o = tck_q;
  assign tms_o = tms_q;
  assign tdi_o = tdi_q;
endmodule

// File: tb/tb_jtag_master_shifter.sv
// tb_jtag_master_shifter: directed scans against a behavioural IEEE 1149.1 TAP, with every
// cycle's pin values derived from the expected edge list and the TCK period arithmetic.
module tb_jtag_master_shifter;
  localparam int DIV = 4;
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6, EX2DR = 7;
  localparam int UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;
  logic clk = 0, rst_n = 0, start = 0, tdo = 0;
  logic [1:0] cmd = 0;
  logic [5:0] len = 0;
  logic [31:0] din = 0, dout;
  logic busy, done, err, tck, tms, tdi;
  int tests = 0, fails = 0;
  int tap = TLR, dr_len = 8, ir_len = 5, last_e;
  logic [31:0] dr_pre = 0, ir_pre = 0, dr_sr = 0, ir_sr = 0, tap_dr = 0, tap_ir = 0;
  logic [63:0] last_tms;
  logic synced = 0;
  jtag_master_shifter #(.MAX_LEN(32), .DIV(DIV)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .cmd_i(cmd), .len_i(len), .din_i(din),
    .dout_o(dout), .busy_o(busy), .done_o(done), .err_o(err), .tck_o(tck), .tms_o(tms),
    .tdi_o(tdi), .tdo_i(tdo)
  );
  always #5 clk = ~clk;
  function automatic int tap_next(int s, logic m);
    case (s)
      TLR: return m ? TLR : RTI;
      RTI: return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR: return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR : PADR;
      PADR: return m ? EX2DR : PADR;
      EX2DR: return m ? UPDR : SHDR;
      UPDR: return m ? SELDR : RTI;
      SELIR: return m ? TLR : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR: return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR : PAIR;
      PAIR: return m ? EX2IR : PAIR;
      EX2IR: return m ? UPIR : SHIR;
      UPIR: return m ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction
  always @(posedge tck) begin
    case (tap)
      CAPDR: dr_sr = dr_pre;
      SHDR: dr_sr = (dr_sr >> 1) | (32'(tdi) << (dr_len - 1));
      UPDR: tap_dr = dr_sr;
      CAPIR: ir_sr = ir_pre;
      SHIR: ir_sr = (ir_sr >> 1) | (32'(tdi) << (ir_len - 1));
      UPIR: tap_ir = ir_sr;
      default: ;
    endcase
    tap = tap_next(tap, tms);
  end
  always @(negedge tck) tdo = tap == SHIR ? ir_sr[0] : dr_sr[0];
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask
  task automatic run(input logic [1:0] c, input int l, input logic [31:0] d, input int glitch,
                     input int rst_at, input logic [31:0] exp_dout);
    logic [63:0] etms, etdi;
    logic [5:0] ev;
    logic bad;
    int e, td;
    etms = 0;
    etdi = 0;
    e = 0;
    bad = c == 2'b11 || (c != 2'b10 && (l < 1 || l > 32));
    if (!bad) begin
      if (c == 2'b10 || !synced)
        for (int i = 0; i < 6; i++) begin etms[e] = i < 5; e++; end
      if (c == 2'b00) begin etms[e] = 1; etms[e+1] = 1; e += 4; end
      if (c == 2'b01) begin etms[e] = 1; e += 3; end
      if (c != 2'b10) begin
        for (int k = 0; k < l; k++) begin etms[e] = k == l - 1; etdi[e] = d[k]; e++; end
        etms[e] = 1;
        e += 2;
      end
    end
    last_e = e;
    last_tms = etms;
    td = 1 + 2 * DIV * e;
    start = 1;
    cmd = c;
    len = l[5:0];
    din = d;
    @(negedge clk);
    din = ~d;
    for (int t = 1; t <= td + 1; t++) begin
      start = t == glitch;
      if (t == glitch) begin cmd = 2'b00; len = 6'd5; end
      if (t == rst_at) begin
        rst_n = 0;
        #1;
        chk("reset_pins", {busy, done, err, tck, tms, tdi, dout}, 0);
        repeat (2) begin
          @(negedge clk);
          chk("reset_no_done", {busy, done, err, tck}, 0);
        end
        rst_n = 1;
        synced = 0;
        return;
      end
      if (t < td)
        ev = {3'b100, ((t - 1) % (2 * DIV)) >= DIV, etms[(t-1)/(2*DIV)], etdi[(t-1)/(2*DIV)]};
      else if (t == td) ev = {2'b01, bad, 3'b000};
      else ev = 0;
      chk("pins", {busy, done, err, tck, tms, tdi}, {58'b0, ev});
      if (t == td && c != 2'b10) chk("dout", dout, exp_dout);
      @(negedge clk);
    end
    start = 0;
    if (!bad) synced = 1;
  endtask
  initial begin
    #3;
    chk("reset_state", {busy, done, err, tck, tms, tdi, dout}, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    dr_len = 8; dr_pre = 32'h3C;
    run(2'b01, 8, 32'hA5, 0, 0, 32'h3C);
    chk("t1_edges", last_e, 19);
    chk("t1_tms", last_tms[18:0], 19'b0110000000001011111);
    chk("t1_td", 1 + 2 * DIV * last_e, 153);
    chk("t1_dr", tap_dr, 32'hA5);
    ir_len = 5; ir_pre = 32'h15;
    run(2'b00, 5, 32'h03, 0, 0, 32'h15);
    chk("t2_tms", last_tms[10:0], 11'b01100000011);
    chk("t2_td", 1 + 2 * DIV * last_e, 89);
    chk("t2_ir", tap_ir, 32'h03);
    chk("t2_rti", tap, RTI);
    dr_len = 1; dr_pre = 32'h1;
    run(2'b01, 1, 32'h1, 0, 0, 32'h1);
    chk("t3_tms", {last_e, last_tms[5:0]}, {32'd6, 6'b011001});
    chk("t3_dr", tap_dr, 32'h1);
    dr_len = 32; dr_pre = 32'h12345678;
    run(2'b01, 32, 32'hDEADBEEF, 100, 0, 32'h12345678);
    chk("t4_dr", tap_dr, 32'hDEADBEEF);
    run(2'b01, 0, 32'hFFFF, 0, 0, 32'h12345678);
    run(2'b11, 8, 32'hFFFF, 0, 0, 32'h12345678);
    run(2'b01, 33, 32'hFFFF, 0, 0, 32'h12345678);
    dr_len = 8;
    run(2'b01, 8, 32'h5A, 0, 53, 0);
    dr_pre = 32'h81;
    run(2'b01, 8, 32'hC3, 0, 0, 32'h81);
    chk("t6_sync_tms", last_tms[5:0], 6'b011111);
    chk("t6_dr", tap_dr, 32'hC3);
    run(2'b10, 0, 0, 0, 0, 0);
    chk("reset_cmd_tlr_rti", tap, RTI);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
